// File: rtl/div_unit.sv
// Iterative 32-bit integer divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed-overflow ops one cycle after start.
module div_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_div_op,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_operand_b,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_div_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_divisor;
  logic        r_is_rem;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_special;
  logic [31:0] r_special_res;
  logic [31:0] r_result;

  logic [1:0]  w_state_nxt;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_special_res;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_calc_res;

  // Operand decode at acceptance; op bit 0 selects unsigned, bit 1 selects remainder.
  always_comb begin
    w_signed   = ~i_div_op[0];
    w_a_neg    = w_signed & i_operand_a[31];
    w_b_neg    = w_signed & i_operand_b[31];
    w_a_mag    = w_a_neg ? (32'd0 - i_operand_a) : i_operand_a;
    w_b_mag    = w_b_neg ? (32'd0 - i_operand_b) : i_operand_b;
    w_div_zero = (i_operand_b == 32'd0);
    w_ovf      = w_signed & (i_operand_a == 32'h8000_0000) & (i_operand_b == 32'hFFFF_FFFF);
    w_special  = w_div_zero | w_ovf;
    if (w_div_zero) begin
      w_special_res = i_div_op[1] ? i_operand_a : 32'hFFFF_FFFF;
    end else begin
      w_special_res = i_div_op[1] ? 32'h0 : 32'h8000_0000;
    end
  end

  // Restoring step: the remainder stays below the divisor, so bit 32 of the difference is
  // exactly the borrow.
  always_comb begin
    w_shift    = {1'b0, r_rem} << 1;
    w_shift[0] = r_quo[31];
    w_diff     = w_shift - {1'b0, r_divisor};
    w_ge       = ~w_diff[32];
    w_rem_nxt  = w_ge ? w_diff[31:0] : w_shift[31:0];
    w_quo_nxt  = {r_quo[30:0], w_ge};
    w_quo_fix  = r_neg_q ? (32'd0 - w_quo_nxt) : w_quo_nxt;
    w_rem_fix  = r_neg_r ? (32'd0 - w_rem_nxt) : w_rem_nxt;
    w_calc_res = r_is_rem ? w_rem_fix : w_quo_fix;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
`ifdef DIV_EARLY_OUT_EN
          w_state_nxt = w_special ? ST_DONE : ST_CALC;
`else
          w_state_nxt = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        if (r_cnt == 5'd31) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 5'd0;
      r_rem         <= 32'd0;
      r_quo         <= 32'd0;
      r_divisor     <= 32'd0;
      r_is_rem      <= 1'b0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_special     <= 1'b0;
      r_special_res <= 32'd0;
      r_result      <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_cnt         <= 5'd0;
            r_rem         <= 32'd0;
            r_quo         <= w_a_mag;
            r_divisor     <= w_b_mag;
            r_is_rem      <= i_div_op[1];
            r_neg_q       <= w_a_neg ^ w_b_neg;
            r_neg_r       <= w_a_neg;
            r_special     <= w_special;
            r_special_res <= w_special_res;
`ifdef DIV_EARLY_OUT_EN
            if (w_special) begin
              r_result <= w_special_res;
            end
`endif
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 5'd1;
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_cnt == 5'd31) begin
            r_result <= r_special ? r_special_res : w_calc_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_valid    = (r_state == ST_DONE);
  assign o_div_data = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized ops against an arithmetic model.
// Honours DIV_EARLY_OUT_EN when computing the expected latency of special cases.
module tb_div_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_div_op;
  logic [31:0] i_operand_a;
  logic [31:0] i_operand_b;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_div_data;

  int n_vec = 0;
  int n_err = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SpecialLat = 1;
`else
  localparam int SpecialLat = 33;
`endif

  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRem  = 2'b10;
  localparam logic [1:0] OpRemu = 2'b11;

  div_unit dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_div_op    (i_div_op),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_div_data  (o_div_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    sa = a;
    sb = b;
    case (op)
      OpDiv:   return sa / sb;
      OpDivu:  return a / b;
      OpRem:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'd0) return SpecialLat;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SpecialLat;
    return 33;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge i_clk);
    i_start     = 1'b1;
    i_div_op    = op;
    i_operand_a = a;
    i_operand_b = b;
    @(posedge i_clk);
  endtask

  // Returns at the falling edge where o_valid is first seen; lat counts edges from acceptance.
  // Operands are scrambled right after acceptance; intr > 0 injects a DIVU 9/3 pulse.
  task automatic wait_valid(input int intr, output logic [31:0] d, output int lat);
    d = 32'h0;
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clk);
      lat++;
      if (lat == 1) begin
        i_start     = 1'b0;
        i_div_op    = 2'($urandom);
        i_operand_a = $urandom;
        i_operand_b = $urandom;
        check_val("busy_after_accept", {31'd0, o_busy}, 32'd1);
      end
      if (intr > 0 && lat == intr) begin
        i_start     = 1'b1;
        i_div_op    = OpDivu;
        i_operand_a = 32'd9;
        i_operand_b = 32'd3;
      end
      if (intr > 0 && lat == intr + 1) i_start = 1'b0;
      if (o_valid) begin
        d = o_div_data;
        return;
      end
    end
    check_val("valid_timeout", {31'd0, o_valid}, 32'd1);
    lat = -1;
  endtask

  task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    logic [31:0] d;
    int lat;
    issue(op, a, b);
    wait_valid(0, d, lat);
    check_val({tag, "_data"}, d, model_res(op, a, b));
    check_val({tag, "_lat"}, lat, model_lat(op, a, b));
    @(negedge i_clk);
    check_val({tag, "_valid_drop"}, {31'd0, o_valid}, 32'd0);
    check_val({tag, "_busy_drop"}, {31'd0, o_busy}, 32'd0);
    check_val({tag, "_hold"}, o_div_data, d);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int lat;
    int pulses;

    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_div_op    = 2'b00;
    i_operand_a = 32'd0;
    i_operand_b = 32'd0;
    repeat (3) @(negedge i_clk);
    check_val("rst_busy", {31'd0, o_busy}, 32'd0);
    check_val("rst_valid", {31'd0, o_valid}, 32'd0);
    check_val("rst_data", o_div_data, 32'd0);
    i_rst = 1'b0;

    run_check("divu_100_7", OpDivu, 32'd100, 32'd7);
    run_check("remu_100_7", OpRemu, 32'd100, 32'd7);
    run_check("div_m100_7", OpDiv, 32'hFFFF_FF9C, 32'd7);
    run_check("rem_m100_7", OpRem, 32'hFFFF_FF9C, 32'd7);
    run_check("div_by0", OpDiv, 32'd5, 32'd0);
    run_check("remu_by0", OpRemu, 32'd5, 32'd0);
    run_check("rem_by0_neg", OpRem, 32'hFFFF_FFF0, 32'd0);
    run_check("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("divu_max", OpDivu, 32'hFFFF_FFFF, 32'd1);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 20); end
        3: rb = $urandom_range(1, 255) | (rb & 32'h8000_0000);
        default: ;
      endcase
      run_check("rand", rop, ra, rb);
    end

    // Start pulse while busy must be dropped.
    issue(OpDivu, 32'd100, 32'd7);
    wait_valid(10, d, lat);
    check_val("busy_ign_data", d, 32'd14);
    check_val("busy_ign_lat", lat, 32'd33);
    pulses = 0;
    repeat (45) begin
      @(negedge i_clk);
      if (o_valid) pulses++;
    end
    check_val("busy_ign_pulses", pulses, 32'd0);

    // Reset mid-calculation aborts without a result strobe.
    issue(OpDivu, 32'd100, 32'd7);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (14) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check_val("abort_busy", {31'd0, o_busy}, 32'd0);
    check_val("abort_valid", {31'd0, o_valid}, 32'd0);
    check_val("abort_data", o_div_data, 32'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge i_clk);
      if (o_valid) pulses++;
    end
    i_rst = 1'b0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_valid) pulses++;
    end
    check_val("abort_pulses", pulses, 32'd0);
    run_check("after_abort", OpDivu, 32'd9, 32'd3);

    // Back-to-back: start held through DONE is ignored there, accepted on the IDLE edge.
    issue(OpDivu, 32'd100, 32'd7);
    wait_valid(0, d, lat);
    check_val("b2b_first_data", d, 32'd14);
    i_start     = 1'b1;
    i_div_op    = OpRemu;
    i_operand_a = 32'd100;
    i_operand_b = 32'd7;
    @(posedge i_clk);
    @(negedge i_clk);
    check_val("b2b_done_ignored", {31'd0, o_busy}, 32'd0);
    @(posedge i_clk);
    wait_valid(0, d, lat);
    check_val("b2b_second_data", d, 32'd2);
    check_val("b2b_gap", lat + 1, 32'd34);

    repeat (3) @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 i_rst  input  1  asynchronous active-high reset.
REQ-004 i_start  input  1  request pulse; sampled on a rising edge only while idle.
REQ-005 i_div_op  input  2  operation: 2'b00 DIV (signed quotient), 2'b01 DIVU, 2'b10 REM (signed remainder), 2'b11 REMU.
REQ-006 i_operand_a  input  32  dividend.
REQ-007 i_operand_b  input  32  divisor.
REQ-008 o_busy  output  1  high from the cycle after start acceptance until o_valid deasserts.
REQ-009 o_valid  output  1  one-cycle result strobe.
REQ-010 o_div_data  output  32  result; held stable from o_valid until the next accepted start.

Function
REQ-011 The FSM SHALL have states IDLE, CALC, DONE; IDLE->CALC on i_start=1, CALC->DONE after 32 iterations, DONE->IDLE unconditionally after one cycle.
REQ-012 On acceptance, the block SHALL latch operands and i_div_op; later input changes SHALL have no effect on the current operation.
REQ-013 CALC SHALL perform restoring division on operand magnitudes, one quotient bit per cycle, MSB first, via a 33-bit partial remainder.
REQ-014 Signed ops SHALL take magnitudes; quotient is negated if operand signs differ; remainder takes the sign of the dividend.
REQ-015 o_valid SHALL be high exactly 33 cycles after the accepting edge (normal path), for exactly one cycle, in state DONE.
REQ-016 i_start while o_busy=1 SHALL be ignored (no restart, no queueing).
REQ-017 i_start high in DONE SHALL be ignored; a start on the first IDLE edge after DONE SHALL be accepted (back-to-back throughput 34 cycles).
REQ-018 Divide by zero SHALL yield quotient 32'hFFFF_FFFF (DIV, DIVU) and remainder = i_operand_a (REM, REMU).
REQ-019 Signed overflow (a=32'h8000_0000, b=32'hFFFF_FFFF, DIV/REM) SHALL yield quotient 32'h8000_0000, remainder 32'h0.
REQ-020 Special cases of REQ-018/019 SHALL be detected at acceptance and SHALL override the iterative result.
REQ-021 All arithmetic SHALL be 32-bit, modulo 2^32; no exception or flag outputs.

Reset
REQ-022 While i_rst=1: state IDLE, o_busy=0, o_valid=0, o_div_data=32'h0, iteration counter and internal registers cleared.
REQ-023 Reset asserted mid-CALC or in DONE SHALL abort the operation immediately with no o_valid pulse; the first accepted start after release SHALL behave as from power-up.

Configuration
REQ-024 Macro DIV_EARLY_OUT_EN, when defined, SHALL send special-case operations (REQ-018/019) from IDLE directly to DONE, so o_valid is high 1 cycle after the accepting edge.
REQ-025 When DIV_EARLY_OUT_EN is undefined, special cases SHALL use the full 33-cycle latency of REQ-015 with the forced result; all ops then have fixed latency.
REQ-026 Results SHALL be identical with and without the macro; only latency differs.

Verification
REQ-027 DIVU a=100, b=7 -> o_valid at cycle 33, o_div_data=14; REMU same operands -> 2.
REQ-028 DIV a=-100 (32'hFFFF_FF9C), b=7 -> 32'hFFFF_FFF2 (-14); REM same -> 32'hFFFF_FFFE (-2).
REQ-029 DIV a=5, b=0 -> 32'hFFFF_FFFF; REMU a=5, b=0 -> 5; DIV a=32'h8000_0000, b=-1 -> 32'h8000_0000; latency 1 with DIV_EARLY_OUT_EN, 33 without.
REQ-030 Start DIVU 100/7, pulse i_start with DIVU 9/3 at cycle 10 -> single o_valid at cycle 33 with 14; second request dropped.
REQ-031 Assert i_rst at cycle 15 of DIVU 100/7 -> outputs 0 immediately, no o_valid; after release, DIVU 9/3 -> 3 at cycle 33.
REQ-032 Back-to-back DIVU 100/7 then REMU 100/7 with start on first IDLE edge -> o_valid pulses 34 cycles apart carrying 14 then 2.
